// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : RV32I fetch stage with the IF/ID pipeline register. Keeps
//               one instruction-memory request outstanding at a time, parks
//               a response that lands during an IF/ID stall in a one-entry
//               skid buffer, and applies redirects resolved in ID.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stall_pc,
    input  logic        i_stall_if_id,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_icache_busy,
    input  logic        i_imem_valid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_if_id_valid,
    output logic [31:0] o_if_id_inst,
    output logic [31:0] o_if_id_pc,
    output logic [31:0] o_if_id_pc_plus4,
    output logic        o_fetch_busy
);

    // FETCH: a request is pending, nothing outstanding.
    // WAIT : one request outstanding, its address is in r_req_pc.
    // HOLD : a response is parked in the skid buffer (skid is full exactly
    //        while in this state).
    localparam logic [1:0] c_FETCH = 2'd0;
    localparam logic [1:0] c_WAIT  = 2'd1;
    localparam logic [1:0] c_HOLD  = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_req_pc;
    logic        r_kill;
    logic [31:0] r_skid_inst;
    logic [31:0] r_skid_pc;
    logic        r_if_id_valid;
    logic [31:0] r_if_id_inst;
    logic [31:0] r_if_id_pc;

    logic        w_deliver_ok;
    logic        w_issue;
    logic        w_accept;
    logic        w_deliver_resp;
    logic        w_deliver_skid;
    logic [31:0] w_redirect_pc;
    logic        w_unused_redirect_lsbs;

    assign w_deliver_ok   = !i_stall_if_id && !i_redirect;
    assign w_deliver_resp = (r_state == c_WAIT) && i_imem_valid && !r_kill && w_deliver_ok;
    assign w_deliver_skid = (r_state == c_HOLD) && w_deliver_ok;

    // A follow-on request may only go out in WAIT when the current response
    // is being consumed straight into IF/ID, keeping one request in flight.
    assign w_issue  = !i_stall_pc && !i_redirect &&
                      ((r_state == c_FETCH) || w_deliver_resp);
    assign w_accept = w_issue && !i_icache_busy && i_rst_n;

    assign w_redirect_pc          = {i_redirect_pc[31:2], 2'b00};
    assign w_unused_redirect_lsbs = &{1'b0, i_redirect_pc[1:0]};

    assign o_imem_req       = w_issue && i_rst_n;
    assign o_imem_addr      = r_pc;
    assign o_fetch_busy     = (r_state == c_WAIT) && !i_imem_valid;
    assign o_if_id_valid    = r_if_id_valid;
    assign o_if_id_inst     = r_if_id_inst;
    assign o_if_id_pc       = r_if_id_pc;
    assign o_if_id_pc_plus4 = r_if_id_pc + 32'd4;

    // Request sequencing: PC, outstanding-request tracking, kill and skid.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= c_FETCH;
            r_pc        <= RESET_PC;
            r_req_pc    <= RESET_PC;
            r_kill      <= 1'b0;
            r_skid_inst <= NOP_INST;
            r_skid_pc   <= 32'd0;
        end else if (i_redirect) begin
            r_pc <= w_redirect_pc;
            // An in-flight request whose response has not yet arrived must be
            // drained and dropped before the target can be fetched.
            if ((r_state == c_WAIT) && !i_imem_valid) begin
                r_kill  <= 1'b1;
                r_state <= c_WAIT;
            end else begin
                r_kill  <= 1'b0;
                r_state <= c_FETCH;
            end
        end else begin
            if (w_accept) begin
                r_req_pc <= r_pc;
                r_pc     <= r_pc + 32'd4;
            end
            case (r_state)
                c_FETCH: begin
                    if (w_accept) begin
                        r_state <= c_WAIT;
                    end
                end
                c_WAIT: begin
                    if (i_imem_valid) begin
                        if (r_kill) begin
                            r_kill  <= 1'b0;
                            r_state <= c_FETCH;
                        end else if (!i_stall_if_id) begin
                            r_state <= w_accept ? c_WAIT : c_FETCH;
                        end else begin
                            r_skid_inst <= i_imem_rdata;
                            r_skid_pc   <= r_req_pc;
                            r_state     <= c_HOLD;
                        end
                    end
                end
                c_HOLD: begin
                    if (w_deliver_ok) begin
                        r_state <= c_FETCH;
                    end
                end
                default: begin
                    r_state <= c_FETCH;
                end
            endcase
        end
    end

    // IF/ID register: hold on stall, load a response or the skid, else bubble.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_if_id_valid <= 1'b0;
            r_if_id_inst  <= NOP_INST;
            r_if_id_pc    <= 32'd0;
        end else if (i_stall_if_id && !i_redirect) begin
            r_if_id_valid <= r_if_id_valid;
        end else if (w_deliver_resp) begin
            r_if_id_valid <= 1'b1;
            r_if_id_inst  <= i_imem_rdata;
            r_if_id_pc    <= r_req_pc;
        end else if (w_deliver_skid) begin
            r_if_id_valid <= 1'b1;
            r_if_id_inst  <= r_skid_inst;
            r_if_id_pc    <= r_skid_pc;
        end else begin
            r_if_id_valid <= 1'b0;
            r_if_id_inst  <= NOP_INST;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Directed self-checking bench for fetch_stage. A small memory
//               responder returns addr+0x1000 after a programmable latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_stall_pc;
    logic        i_stall_if_id;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_icache_busy;
    logic        i_imem_valid;
    logic [31:0] i_imem_rdata;
    logic        o_if_id_valid;
    logic [31:0] o_if_id_inst;
    logic [31:0] o_if_id_pc;
    logic [31:0] o_if_id_pc_plus4;
    logic        o_fetch_busy;

    int n_checks = 0;
    int n_errors = 0;

    int          mem_lat  = 1;
    logic [3:0]  mem_cnt  = 4'd0;
    logic [31:0] mem_addr = 32'd0;

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INST (32'h0000_0013)
    ) u_dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_stall_pc       (i_stall_pc),
        .i_stall_if_id    (i_stall_if_id),
        .i_redirect       (i_redirect),
        .i_redirect_pc    (i_redirect_pc),
        .o_imem_req       (o_imem_req),
        .o_imem_addr      (o_imem_addr),
        .i_icache_busy    (i_icache_busy),
        .i_imem_valid     (i_imem_valid),
        .i_imem_rdata     (i_imem_rdata),
        .o_if_id_valid    (o_if_id_valid),
        .o_if_id_inst     (o_if_id_inst),
        .o_if_id_pc       (o_if_id_pc),
        .o_if_id_pc_plus4 (o_if_id_pc_plus4),
        .o_fetch_busy     (o_fetch_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Memory responder: latches an accepted request, answers mem_lat cycles later.
    always @(posedge i_clk) begin
        if (o_imem_req && !i_icache_busy) begin
            mem_cnt  <= mem_lat[3:0];
            mem_addr <= o_imem_addr;
        end else if (mem_cnt != 4'd0) begin
            mem_cnt <= mem_cnt - 4'd1;
        end
    end
    assign i_imem_valid = (mem_cnt == 4'd1);
    assign i_imem_rdata = mem_addr + 32'h0000_1000;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic v, input logic [31:0] inst,
                              input logic [31:0] pc);
        check({tag, "_valid"}, {31'd0, o_if_id_valid}, {31'd0, v});
        check({tag, "_inst"}, o_if_id_inst, inst);
        check({tag, "_pc"}, o_if_id_pc, pc);
    endtask

    task automatic check_req(input string tag, input logic req, input logic [31:0] addr);
        check({tag, "_req"}, {31'd0, o_imem_req}, {31'd0, req});
        if (req) check({tag, "_addr"}, o_imem_addr, addr);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_rst_n       = 1'b0;
        i_stall_pc    = 1'b0;
        i_stall_if_id = 1'b0;
        i_redirect    = 1'b0;
        i_redirect_pc = 32'd0;
        i_icache_busy = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        check_ifid("rst", 1'b0, 32'h13, 32'h0);
        check("rst_pc4", o_if_id_pc_plus4, 32'h4);
        check_req("rst", 1'b0, 32'h0);

        // Reset release and a streaming fetch at one instruction per cycle
        i_rst_n = 1'b1;
        #1;
        check_req("c0", 1'b1, 32'h0);
        step(); check_req("c1", 1'b1, 32'h4); check("c1_v", {31'd0, o_if_id_valid}, 32'd0);
        step(); check_req("c2", 1'b1, 32'h8); check_ifid("c2", 1'b1, 32'h1000, 32'h0);
        step(); check_req("c3", 1'b1, 32'hC); check_ifid("c3", 1'b1, 32'h1004, 32'h4);

        // Stall while C's response lands: it must park in the skid
        step(); i_stall_pc = 1'b1; i_stall_if_id = 1'b1; #1;
        check_ifid("c4", 1'b1, 32'h1008, 32'h8); check_req("c4", 1'b0, 32'h0);
        step(); check_ifid("c5", 1'b1, 32'h1008, 32'h8); check_req("c5", 1'b0, 32'h0);
        check("c5_busy", {31'd0, o_fetch_busy}, 32'd0);
        step(); i_stall_pc = 1'b0; i_stall_if_id = 1'b0; #1;
        check_ifid("c6", 1'b1, 32'h1008, 32'h8); check_req("c6", 1'b0, 32'h0);
        step(); check_ifid("c7", 1'b1, 32'h100C, 32'hC); check_req("c7", 1'b1, 32'h10);
        step(); check_ifid("c8", 1'b0, 32'h13, 32'hC); check_req("c8", 1'b1, 32'h14);
        step(); check_ifid("c9", 1'b1, 32'h1010, 32'h10); check_req("c9", 1'b1, 32'h18);
        step(); check_req("c10", 1'b1, 32'h1C);
        step(); check_req("c11", 1'b1, 32'h20); mem_lat = 3;

        // Redirect while the 0x20 request is outstanding: response dropped
        step(); i_redirect = 1'b1; i_redirect_pc = 32'h103; #1;
        check("c12_busy", {31'd0, o_fetch_busy}, 32'd1); check_req("c12", 1'b0, 32'h0);
        step(); i_redirect = 1'b0; #1;
        check_req("c13", 1'b0, 32'h0); check("c13_v", {31'd0, o_if_id_valid}, 32'd0);
        step(); check_req("c14", 1'b0, 32'h0); check("c14_v", {31'd0, o_if_id_valid}, 32'd0);
        step(); mem_lat = 1; #1;
        check_req("c15", 1'b1, 32'h100); check("c15_v", {31'd0, o_if_id_valid}, 32'd0);
        step(); check_req("c16", 1'b1, 32'h104); check("c16_v", {31'd0, o_if_id_valid}, 32'd0);
        step(); check_ifid("c17", 1'b1, 32'h1100, 32'h100);
        i_redirect = 1'b1; i_redirect_pc = 32'h40; #1;
        check_req("c17", 1'b0, 32'h0);

        // icache busy for 4 cycles: request repeats, PC held
        step(); i_redirect = 1'b0; i_icache_busy = 1'b1; #1;
        for (int k = 0; k < 4; k++) begin
            check_req("busy", 1'b1, 32'h40);
            check_ifid("busy", 1'b0, 32'h13, 32'h100);
            if (k < 3) step();
        end
        step(); i_icache_busy = 1'b0; #1;
        check_req("c22", 1'b1, 32'h40);
        step(); check_req("c23", 1'b1, 32'h44); check_ifid("c23", 1'b0, 32'h13, 32'h100);
        step(); check_ifid("c24", 1'b1, 32'h1040, 32'h40);

        // Address wrap at the top of the address space
        i_redirect = 1'b1; i_redirect_pc = 32'hFFFF_FFFE;
        step(); i_redirect = 1'b0; #1;
        check_req("c25", 1'b1, 32'hFFFF_FFFC);
        step(); check_req("c26", 1'b1, 32'h0);
        step(); check_ifid("c27", 1'b1, 32'h0000_0FFC, 32'hFFFF_FFFC);
        check("c27_pc4", o_if_id_pc_plus4, 32'h0);
        mem_lat = 3;

        // Asynchronous reset in WAIT with a response still in flight
        step(); check_ifid("c28", 1'b1, 32'h1000, 32'h0);
        check("c28_busy", {31'd0, o_fetch_busy}, 32'd1);
        #2; i_rst_n = 1'b0; #1;
        check_ifid("arst", 1'b0, 32'h13, 32'h0);
        check_req("arst", 1'b0, 32'h0);
        check("arst_busy", {31'd0, o_fetch_busy}, 32'd0);
        step(); check_req("c29", 1'b0, 32'h0);
        step(); i_rst_n = 1'b1; mem_lat = 1; #1;
        check_req("c30", 1'b1, 32'h0);
        step(); check("c31_v", {31'd0, o_if_id_valid}, 32'd0); check_req("c31", 1'b1, 32'h4);
        step(); check_ifid("c32", 1'b1, 32'h1000, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
